dmem_wb_stage: RTL and testbench

// - Stage directly downstream of MEM: takes MEM's address, store data and byte masks, runs the data-cache handshake, and produces the WB packet.
// - Stalls upstream until dcache responds, then aligns and sign/zero-extends load data.
// - Non-memory instructions pass through with one cycle of latency.
// - Detects misaligned accesses and cache timeouts.

---
 rtl/dmem_wb_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wb_stage.sv
// dmem_wb_stage
// Sits between MEM and WB. Memory instructions are held here while the data
// cache handshake runs, then the load data is aligned and extended into a WB
// packet. Non-memory instructions pass through after one register stage.
// Misaligned word/halfword accesses never reach the cache, and a watchdog
// abandons a request the cache never answers.
//
// Parameters
//   TIMEOUT      max BUSY cycles without dc_resp before giving up (0 = never)
// Ports
//   clk, rst     rising-edge clock, asynchronous active-low reset
//   mem_*        instruction fields from MEM (valid, addr, wdata, masks,
//                funct3, rd, rd_we)
//   stall_out    upstream must hold its register this cycle
//   dc_read/dc_write/dc_addr/dc_wdata/dc_mbe   request to the data cache
//   dc_rdata/dc_resp                           response from the data cache
//   wb_valid/wb_rd/wb_we/wb_data               packet to writeback
//   err_misalign/err_timeout                   sticky error flags
module dmem_wb_stage #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [2:0]  mem_funct3,
    input  logic [4:0]  mem_rd,
    input  logic        mem_rd_we,
    output logic        stall_out,
    output logic        dc_read,
    output logic        dc_write,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_mbe,
    input  logic [31:0] dc_rdata,
    input  logic        dc_resp,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wd_count;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wmask;
    logic        lat_store;
    logic [2:0]  lat_funct3;
    logic [4:0]  lat_rd;
    logic        lat_we;

    logic        is_mem;
    logic        misaligned;
    logic        accept;
    logic        timeout_hit;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign is_mem = (|mem_rmask) | (|mem_wmask);

    // funct3[1:0] encodes access size for both loads and stores:
    // 00 byte, 01 halfword, 10 word.
    always_comb begin
        misaligned = 1'b0;
        case (mem_funct3[1:0])
            2'b10:   misaligned = |mem_addr[1:0];
            2'b01:   misaligned = mem_addr[0];
            default: misaligned = 1'b0;
        endcase
    end

    // Next state and stall. A response in the same cycle the watchdog would
    // fire is treated as a normal completion. stall_out drops in the cycle
    // BUSY ends so upstream can advance into the following IDLE cycle.
    always_comb begin
        state_next  = state;
        stall_out   = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid && is_mem && !misaligned) begin
                    accept     = 1'b1;
                    stall_out  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (dc_resp) begin
                    state_next = IDLE;
                end else if ((TIMEOUT != 0) && (wd_count == CNT_W'(TIMEOUT - 1))) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load alignment: bring the addressed byte/halfword down to bit 0, then
    // extend according to funct3 (bit 2 set means unsigned).
    always_comb begin
        shifted   = dc_rdata >> {lat_addr[1:0], 3'b000};
        load_data = shifted;
        case (lat_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign dc_addr  = {lat_addr[31:2], 2'b00};
    assign dc_wdata = lat_wdata << {lat_addr[1:0], 3'b000};

    always_comb begin
        dc_mbe = 4'b0000;
        if (dc_write) begin
            dc_mbe = lat_wmask;
        end else if (dc_read) begin
            dc_mbe = 4'b1111;
        end
    end

    // Datapath: latches the accepted instruction, owns the cache request
    // lines, the watchdog counter, the WB packet and the sticky flags.
    // wb_valid/wb_we default low so every packet lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_wmask    <= '0;
            lat_store    <= 1'b0;
            lat_funct3   <= '0;
            lat_rd       <= '0;
            lat_we       <= 1'b0;
            dc_read      <= 1'b0;
            dc_write     <= 1'b0;
            wd_count     <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_we        <= 1'b0;
            wb_data      <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            if (state == IDLE) begin
                if (mem_valid && !is_mem) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= mem_rd;
                    wb_we    <= mem_rd_we;
                    wb_data  <= mem_addr;
                end else if (mem_valid && misaligned) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= mem_rd;
                    wb_data      <= '0;
                    err_misalign <= 1'b1;
                end else if (accept) begin
                    lat_addr   <= mem_addr;
                    lat_wdata  <= mem_wdata;
                    lat_wmask  <= mem_wmask;
                    lat_store  <= |mem_wmask;
                    lat_funct3 <= mem_funct3;
                    lat_rd     <= mem_rd;
                    lat_we     <= mem_rd_we;
                    dc_read    <= ~(|mem_wmask);
                    dc_write   <= |mem_wmask;
                    wd_count   <= '0;
                end
            end else begin
                if (dc_resp) begin
                    dc_read  <= 1'b0;
                    dc_write <= 1'b0;
                    wd_count <= '0;
                    wb_valid <= 1'b1;
                    wb_rd    <= lat_rd;
                    wb_we    <= lat_store ? 1'b0 : lat_we;
                    wb_data  <= lat_store ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    dc_read     <= 1'b0;
                    dc_write    <= 1'b0;
                    wd_count    <= '0;
                    err_timeout <= 1'b1;
                    wb_valid    <= 1'b1;
                    wb_rd       <= lat_rd;
                    wb_data     <= '0;
                end else begin
                    wd_count <= wd_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_wb_stage.sv
// tb_dmem_wb_stage
// Self-checking bench for dmem_wb_stage with a short watchdog (TIMEOUT=8).
// Directed cases cover pass-through, sign/zero-extended loads, a shifted
// halfword store, a misaligned word, a watchdog expiry and a reset in the
// middle of a cache request; a randomized run follows. Expected values come
// from a per-instruction reference model (size/offset arithmetic).
module tb_dmem_wb_stage;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic        mem_rd_we;
    logic        stall_out;
    logic        dc_read;
    logic        dc_write;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_mbe;
    logic [31:0] dc_rdata;
    logic        dc_resp;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        err_misalign;
    logic        err_timeout;

    int vectors = 0;
    int miscompares = 0;
    bit exp_mis = 1'b0;
    bit exp_to = 1'b0;

    dmem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_funct3(mem_funct3),
        .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .stall_out(stall_out),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_mbe(dc_mbe), .dc_rdata(dc_rdata),
        .dc_resp(dc_resp), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data), .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expv);
        end
    endtask

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] size_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Reference load result: pick the addressed bytes arithmetically, then
    // sign-extend by subtracting 2^n when the top bit is set.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
        int unsigned v;
        v = rdata >> (8 * off);
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    task automatic checkFlags();
        checkOutput("err_misalign", 32'(err_misalign), 32'(exp_mis));
        checkOutput("err_timeout", 32'(err_timeout), 32'(exp_to));
    endtask

    // Presents one instruction (kind 0 non-mem, 1 load, 2 store) and follows
    // it to its WB packet. Starts and ends 1 time unit after a rising edge,
    // so consecutive calls exercise back-to-back acceptance.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [4:0] rd, input logic we,
                                 input int delay, input logic [31:0] rdata);
        logic [1:0] off;
        bit mis;
        off = addr[1:0];
        mis = (kind != 0) && ((f3[1:0] == 2'b10 && off != 2'b00) || (f3[1:0] == 2'b01 && off[0]));
        mem_valid  = 1'b1;
        mem_addr   = addr;
        mem_wdata  = wdata;
        mem_funct3 = f3;
        mem_rd     = rd;
        mem_rd_we  = we;
        mem_rmask  = (kind == 1) ? size_mask(f3, off) : 4'b0000;
        mem_wmask  = (kind == 2) ? size_mask(f3, off) : 4'b0000;
        #1;
        if (kind == 0 || mis) begin
            checkOutput("stall_pass", 32'(stall_out), 32'd0);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            checkOutput("wb_valid_pass", 32'(wb_valid), 32'd1);
            checkOutput("dc_req_pass", 32'({dc_read, dc_write}), 32'd0);
            if (kind == 0) begin
                checkOutput("wb_rd_pass", 32'(wb_rd), 32'(rd));
                checkOutput("wb_we_pass", 32'(wb_we), 32'(we));
                checkOutput("wb_data_pass", wb_data, addr);
            end else begin
                exp_mis = 1'b1;
                checkOutput("wb_we_mis", 32'(wb_we), 32'd0);
            end
        end else begin
            checkOutput("stall_accept", 32'(stall_out), 32'd1);
            @(posedge clk); #1;
            for (int j = 0; j < TO; j++) begin
                if (j == 0) begin
                    checkOutput("dc_read", 32'(dc_read), 32'(kind == 1));
                    checkOutput("dc_write", 32'(dc_write), 32'(kind == 2));
                    checkOutput("dc_addr", dc_addr, {addr[31:2], 2'b00});
                    checkOutput("dc_mbe", 32'(dc_mbe), (kind == 2) ? 32'(size_mask(f3, off)) : 32'hF);
                    if (kind == 2) checkOutput("dc_wdata", dc_wdata, wdata << (8 * off));
                end
                checkOutput("wb_valid_busy", 32'(wb_valid), 32'd0);
                if (j == delay) begin
                    dc_resp   = 1'b1;
                    dc_rdata  = rdata;
                    mem_valid = 1'b0;
                    #1;
                    checkOutput("stall_resp", 32'(stall_out), 32'd0);
                    @(posedge clk); #1;
                    dc_resp = 1'b0;
                    checkOutput("dc_req_drop", 32'({dc_read, dc_write}), 32'd0);
                    checkOutput("wb_valid_mem", 32'(wb_valid), 32'd1);
                    checkOutput("wb_rd_mem", 32'(wb_rd), 32'(rd));
                    checkOutput("wb_we_mem", 32'(wb_we), (kind == 1) ? 32'(we) : 32'd0);
                    checkOutput("wb_data_mem", wb_data, (kind == 1) ? ref_load(rdata, off, f3) : 32'd0);
                    break;
                end else if (j == TO - 1) begin
                    mem_valid = 1'b0;
                    #1;
                    checkOutput("stall_timeout", 32'(stall_out), 32'd0);
                    @(posedge clk); #1;
                    exp_to = 1'b1;
                    checkOutput("dc_req_timeout", 32'({dc_read, dc_write}), 32'd0);
                    checkOutput("wb_valid_to", 32'(wb_valid), 32'd1);
                    checkOutput("wb_we_to", 32'(wb_we), 32'd0);
                    break;
                end else begin
                    checkOutput("stall_busy", 32'(stall_out), 32'd1);
                    @(posedge clk); #1;
                end
            end
        end
        mem_rmask = 4'b0000;
        mem_wmask = 4'b0000;
        checkFlags();
    endtask

    initial begin
        int unsigned kind;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [2:0]  load_f3 [5];
        int          delay;

        load_f3[0] = 3'b000; load_f3[1] = 3'b001; load_f3[2] = 3'b010;
        load_f3[3] = 3'b100; load_f3[4] = 3'b101;

        rst = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_rmask = '0; mem_wmask = '0; mem_funct3 = '0; mem_rd = '0;
        mem_rd_we = 1'b0; dc_rdata = '0; dc_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_rd_we", 32'({wb_rd, wb_we}), 32'd0);
        checkOutput("rst_dc_req", 32'({dc_read, dc_write}), 32'd0);
        checkOutput("rst_dc_addr", dc_addr, 32'd0);
        checkOutput("rst_dc_mbe", 32'(dc_mbe), 32'd0);
        checkOutput("rst_stall", 32'(stall_out), 32'd0);
        checkFlags();
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b1, 0, 32'h0);
        applyStimulus(1, 32'h0000_1003, 32'h0, 3'b000, 5'd6, 1'b1, 3, 32'h80FF_FFFF);
        checkOutput("lb_value", wb_data, 32'hFFFF_FF80);
        applyStimulus(1, 32'h0000_1003, 32'h0, 3'b100, 5'd7, 1'b1, 3, 32'h80FF_FFFF);
        checkOutput("lbu_value", wb_data, 32'h0000_0080);
        applyStimulus(2, 32'h0000_2002, 32'h0000_ABCD, 3'b001, 5'd0, 1'b0, 2, 32'h0);
        applyStimulus(1, 32'h0000_3001, 32'h0, 3'b010, 5'd8, 1'b1, 0, 32'h0);
        applyStimulus(1, 32'h0000_3000, 32'h0, 3'b010, 5'd9, 1'b1, 100, 32'h0);
        applyStimulus(1, 32'h0000_3004, 32'h0, 3'b010, 5'd10, 1'b1, 0, 32'hDEAD_BEEF);
        checkOutput("lw_after_to", wb_data, 32'hDEAD_BEEF);

        // Reset while a load is outstanding; request must fall with no edge.
        mem_valid = 1'b1; mem_addr = 32'h0000_4000; mem_funct3 = 3'b010;
        mem_rmask = 4'b1111; mem_rd = 5'd11; mem_rd_we = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_rmask = 4'b0000;
        checkOutput("busy_dc_read", 32'(dc_read), 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_mis = 1'b0;
        exp_to  = 1'b0;
        checkOutput("async_dc_read", 32'(dc_read), 32'd0);
        checkOutput("async_stall", 32'(stall_out), 32'd0);
        checkFlags();
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 32'h0000_5002, 32'h0, 3'b001, 5'd12, 1'b1, 1, 32'h8001_7F00);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom;
            if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else           f3 = load_f3[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) addr[0]   = 1'b0;
            end
            delay = $urandom_range(0, 9);
            applyStimulus(int'(kind), addr, $urandom, f3, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), delay, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
